// File: rtl/trace_pkg.sv
// Purpose: shared types for the commit trace buffer (record kinds, record layout, opcode constants).
// Latency: n/a (types and a pure classification helper only).
// Backpressure: n/a.
package trace_pkg;

  // Record payload width. The top-level XLEN parameter is expected to match.
  localparam int TRACE_XLEN = 32;

  // RV32 major opcode for all integer loads (lb/lh/lw/lbu/lhu).
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    REC_NONE  = 2'd0,
    REC_REG   = 2'd1,
    REC_STORE = 2'd2,
    REC_LOAD  = 2'd3
  } rec_kind_e;

  typedef struct packed {
    rec_kind_e             kind;
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] data;
    logic [TRACE_XLEN-1:0] addr;
  } trace_rec_t;

  // Priority: a store flag wins over the opcode, a load wins over rd==x0.
  function automatic rec_kind_e classify(input logic        mem_wrt,
                                         input logic [31:0] instr,
                                         input logic [4:0]  rd);
    if (mem_wrt)                    return REC_STORE;
    else if (instr[6:0] == OPC_LOAD) return REC_LOAD;
    else if (rd == 5'd0)            return REC_NONE;
    else                            return REC_REG;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Purpose: synchronous FIFO of trace records with optional evict-oldest-on-full.
// Latency: 1 cycle push-to-visible; head is read straight from storage (no output register).
// Backpressure: pop is ignored when empty; push when full and not popping is dropped or evicts the head.
//
// Ports: clk_i/rstn_i clock and async active-low reset; push_i/wdata_i write side;
//        pop_i read side (gated internally by empty); rdata_o head entry (undefined when empty);
//        full_o/empty_o/count_o occupancy.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  trace_rec_t                 wdata_i,
  input  logic                       pop_i,
  output trace_rec_t                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH+1);

  trace_rec_t           mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic                 do_pop, do_write, evict;

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CNT_BITS'(DEPTH));
    do_pop   = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves this cycle.
    do_write = push_i & (~full_o | do_pop | OVERWRITE);
    // Overwrite mode: the head is discarded to make room; occupancy is unchanged.
    evict    = push_i & full_o & ~do_pop & OVERWRITE;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (do_write)        wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop || evict) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_write && !do_pop && !full_o) count_d = count_q + CNT_BITS'(1);
    else if (do_pop && !do_write)       count_d = count_q - CNT_BITS'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out while count is zero.
  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Purpose: classify retired instructions into trace records, buffer them, count stall/flush/drop events.
// Latency: 1 cycle from capture to rec_valid_o; counters update on the event edge.
// Backpressure: rec_valid_o/rec_ready_i handshake; when full, newest is dropped or oldest evicted (OVERWRITE).
//
// Ports: clk_i/rstn_i clock and async active-low reset; enable_i gates capture and counting;
//        commit_* retiring instruction; stall_i/flush_i pipeline events; rec_* head record and handshake;
//        count_o occupancy; dropped_o/stall_cnt_o/flush_cnt_o saturating statistics; skip_done_o warm-up over.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int SKIP      = 3,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       enable_i,
  input  logic                       commit_valid_i,
  input  logic [XLEN-1:0]            commit_pc_i,
  input  logic [31:0]                commit_instr_i,
  input  logic [4:0]                 commit_rd_i,
  input  logic [XLEN-1:0]            commit_rd_data_i,
  input  logic [XLEN-1:0]            commit_mem_addr_i,
  input  logic [XLEN-1:0]            commit_mem_data_i,
  input  logic                       commit_mem_wrt_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       rec_valid_o,
  input  logic                       rec_ready_i,
  output logic [1:0]                 rec_kind_o,
  output logic [XLEN-1:0]            rec_pc_o,
  output logic [31:0]                rec_instr_o,
  output logic [4:0]                 rec_rd_o,
  output logic [XLEN-1:0]            rec_data_o,
  output logic [XLEN-1:0]            rec_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [CNT_W-1:0]           dropped_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o,
  output logic                       skip_done_o
);

  localparam int               SKIP_W  = (SKIP > 0) ? $clog2(SKIP+1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  trace_rec_t                 cap_rec, fifo_rdata, head;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic                       capture, skip_done, push, pop_fire, drop_evt;

  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Build the record; fields that do not apply to a kind stay zero.
  always_comb begin
    cap_rec       = '0;
    cap_rec.kind  = classify(commit_mem_wrt_i, commit_instr_i, commit_rd_i);
    cap_rec.pc    = TRACE_XLEN'(commit_pc_i);
    cap_rec.instr = commit_instr_i;
    unique case (cap_rec.kind)
      REC_STORE: begin
        cap_rec.data = TRACE_XLEN'(commit_mem_data_i);
        cap_rec.addr = TRACE_XLEN'(commit_mem_addr_i);
      end
      REC_LOAD: begin
        cap_rec.rd   = commit_rd_i;
        cap_rec.data = TRACE_XLEN'(commit_rd_data_i);
        cap_rec.addr = TRACE_XLEN'(commit_mem_addr_i);
      end
      REC_REG: begin
        cap_rec.rd   = commit_rd_i;
        cap_rec.data = TRACE_XLEN'(commit_rd_data_i);
      end
      default: ;
    endcase
  end

  always_comb begin
    capture   = commit_valid_i & enable_i;
    skip_done = (skip_cnt_q == SKIP_W'(SKIP));
    push      = capture & skip_done;
    pop_fire  = rec_ready_i & ~fifo_empty;
    // Both full-FIFO policies lose one record when nothing leaves this cycle.
    drop_evt  = push & fifo_full & ~pop_fire;

    skip_cnt_d  = skip_cnt_q;
    dropped_d   = dropped_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (capture && !skip_done)                    skip_cnt_d  = skip_cnt_q + SKIP_W'(1);
    if (drop_evt && dropped_q != CNT_MAX)         dropped_d   = dropped_q + CNT_W'(1);
    if (stall_i && enable_i && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_i && enable_i && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      skip_cnt_q  <= '0;
      dropped_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      skip_cnt_q  <= skip_cnt_d;
      dropped_q   <= dropped_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE != 0)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .wdata_i (cap_rec),
    .pop_i   (rec_ready_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign head        = fifo_empty ? '0 : fifo_rdata;
  assign rec_valid_o = ~fifo_empty;
  assign rec_kind_o  = head.kind;
  assign rec_pc_o    = XLEN'(head.pc);
  assign rec_instr_o = head.instr;
  assign rec_rd_o    = head.rd;
  assign rec_data_o  = XLEN'(head.data);
  assign rec_addr_o  = XLEN'(head.addr);
  assign count_o     = fifo_count;
  assign dropped_o   = dropped_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign skip_done_o = skip_done;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  localparam int DEPTH   = 4;
  localparam int SKIP    = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn, enable, cv, mem_wrt, stall, flush, rdy;
  logic [31:0] pc, instr, rd_data, mem_addr, mem_data;
  logic [4:0]  rd;

  logic        v0, v1, sd0, sd1;
  logic [1:0]  kind0, kind1;
  logic [31:0] pc0, pc1, instr0, instr1, data0, data1, addr0, addr1;
  logic [4:0]  rd0, rd1;
  logic [2:0]  cnt0, cnt1;
  logic [CNT_W-1:0] drop0, drop1, stc0, stc1, flc0, flc1;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .SKIP(SKIP), .OVERWRITE(0), .CNT_W(CNT_W)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .commit_valid_i(cv), .commit_pc_i(pc),
    .commit_instr_i(instr), .commit_rd_i(rd), .commit_rd_data_i(rd_data), .commit_mem_addr_i(mem_addr),
    .commit_mem_data_i(mem_data), .commit_mem_wrt_i(mem_wrt), .stall_i(stall), .flush_i(flush),
    .rec_valid_o(v0), .rec_ready_i(rdy), .rec_kind_o(kind0), .rec_pc_o(pc0), .rec_instr_o(instr0),
    .rec_rd_o(rd0), .rec_data_o(data0), .rec_addr_o(addr0), .count_o(cnt0), .dropped_o(drop0),
    .stall_cnt_o(stc0), .flush_cnt_o(flc0), .skip_done_o(sd0));

  commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .SKIP(SKIP), .OVERWRITE(1), .CNT_W(CNT_W)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .commit_valid_i(cv), .commit_pc_i(pc),
    .commit_instr_i(instr), .commit_rd_i(rd), .commit_rd_data_i(rd_data), .commit_mem_addr_i(mem_addr),
    .commit_mem_data_i(mem_data), .commit_mem_wrt_i(mem_wrt), .stall_i(stall), .flush_i(flush),
    .rec_valid_o(v1), .rec_ready_i(rdy), .rec_kind_o(kind1), .rec_pc_o(pc1), .rec_instr_o(instr1),
    .rec_rd_o(rd1), .rec_data_o(data1), .rec_addr_o(addr1), .count_o(cnt1), .dropped_o(drop1),
    .stall_cnt_o(stc1), .flush_cnt_o(flc1), .skip_done_o(sd1));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: queue contents per DUT plus plain integer statistics.
  exp_t q0[$];
  exp_t q1[$];
  int   skip_left, mdrop0, mdrop1, mstall, mflush;

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  function automatic exp_t expect_rec();
    exp_t e;
    e = '0;
    e.pc    = pc;
    e.instr = instr;
    if (mem_wrt) begin
      e.kind = 2'd2; e.data = mem_data; e.addr = mem_addr;
    end else if (instr[6:0] == 7'b0000011) begin
      e.kind = 2'd3; e.rd = rd; e.data = rd_data; e.addr = mem_addr;
    end else if (rd != 5'd0) begin
      e.kind = 2'd1; e.rd = rd; e.data = rd_data;
    end
    return e;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    skip_left = SKIP; mdrop0 = 0; mdrop1 = 0; mstall = 0; mflush = 0;
  endtask

  // Predict the effect of the coming clock edge given the inputs now driven.
  task automatic model_step();
    bit   pop;
    exp_t e;
    pop = rdy && (q0.size() > 0);
    if (cv && enable) begin
      if (skip_left > 0) skip_left--;
      else begin
        e = expect_rec();
        if (q0.size() < DEPTH || pop) begin
          q0.push_back(e);
          q1.push_back(e);
        end else begin
          mdrop0 = sat_inc(mdrop0);
          void'(q1.pop_front());
          q1.push_back(e);
          mdrop1 = sat_inc(mdrop1);
        end
      end
    end
    if (enable && stall) mstall = sat_inc(mstall);
    if (enable && flush) mflush = sat_inc(mflush);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] r,
                            input logic [31:0] rdd, input logic [31:0] ma, input logic [31:0] md,
                            input logic w);
    cv = 1'b1; pc = p; instr = ins; rd = r; rd_data = rdd; mem_addr = ma; mem_data = md; mem_wrt = w;
  endtask

  task automatic rand_commit();
    int sel;
    sel = $urandom_range(0, 3);
    set_commit($urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom), $urandom, $urandom, $urandom, 1'b0);
    case (sel)
      0: begin instr[6:0] = 7'b0100011; mem_wrt = 1'b1; end
      1: instr[6:0] = 7'b0000011;
      2: begin instr[6:0] = 7'b0010011; if ($urandom_range(0, 1) == 1) rd = 5'd0; end
      default: instr[6:0] = 7'b0110011;
    endcase
  endtask

  // Scoreboard monitor: whenever a head is handed over, it must match the model's oldest record.
  always @(negedge clk) begin
    if (rstn && rdy) begin
      if (v0) begin
        if (q0.size() == 0) begin
          n_total++;
          $display("FAIL mon0_extra: dut0 presented pc %0h, model expected no record", pc0);
        end else check("mon0_rec", {kind0, pc0, instr0, rd0, data0, addr0}, q0.pop_front());
      end
      if (v1) begin
        if (q1.size() == 0) begin
          n_total++;
          $display("FAIL mon1_extra: dut1 presented pc %0h, model expected no record", pc1);
        end else check("mon1_rec", {kind1, pc1, instr1, rd1, data1, addr1}, q1.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_dut0_zero"}, {v0, kind0, pc0, instr0, rd0, data0, addr0, cnt0, drop0, stc0, flc0, sd0}, '0);
    check({tag, "_dut1_zero"}, {v1, kind1, pc1, instr1, rd1, data1, addr1, cnt1, drop1, stc1, flc1, sd1}, '0);
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; cv = 1'b0; mem_wrt = 1'b0; stall = 1'b0; flush = 1'b0; rdy = 1'b0;
    pc = '0; instr = '0; rd = '0; rd_data = '0; mem_addr = '0; mem_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Warm-up: the first SKIP commits vanish, the 4th becomes the head.
    for (int i = 0; i < 5; i++) begin
      set_commit(32'h1000 + 32'(4 * i), 32'h00A00093, 5'd1, 32'(i), 32'h0, 32'h0, 1'b0);
      tick();
      check("skip_done", sd0, (i >= SKIP - 1) ? 1'b1 : 1'b0);
    end
    cv = 1'b0;
    check("warmup_count", cnt0, 3'd2);
    check("warmup_head_pc", pc0, 32'h100C);
    rdy = 1'b1;
    repeat (3) tick();
    rdy = 1'b0;

    // Directed classification: REG, STORE, LOAD, NONE.
    set_commit(32'h2000, 32'h00A00093, 5'd1, 32'hA, 32'h55, 32'h66, 1'b0); tick();
    set_commit(32'h2004, 32'h0020A223, 5'd4, 32'h77, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1); tick();
    set_commit(32'h2008, 32'h0040A183, 5'd3, 32'h1234, 32'h8000_0008, 32'h99, 1'b0); tick();
    set_commit(32'h200C, 32'h00000013, 5'd0, 32'h5, 32'h6, 32'h7, 1'b0); tick();
    cv = 1'b0;
    check("reg_head", {kind0, rd0, data0, addr0}, {2'd1, 5'd1, 32'h0000_000A, 32'h0});
    rdy = 1'b1; tick(); rdy = 1'b0;
    check("store_head", {kind0, rd0, data0, addr0}, {2'd2, 5'd0, 32'hDEAD_BEEF, 32'h8000_0004});
    rdy = 1'b1;
    repeat (4) tick();
    rdy = 1'b0;

    // Overflow with no consumer: drop-newest vs evict-oldest.
    for (int i = 0; i < 6; i++) begin
      set_commit(32'h3000 + 32'(4 * i), 32'h00100113, 5'd2, 32'(i), 32'h0, 32'h0, 1'b0);
      tick();
    end
    cv = 1'b0;
    check("ovf_count0", cnt0, 3'd4);
    check("ovf_count1", cnt1, 3'd4);
    check("ovf_drop0", drop0, 4'd2);
    check("ovf_drop1", drop1, 4'd2);
    check("ovf_head0", pc0, 32'h3000);
    check("ovf_head1", pc1, 32'h3008);

    // Full FIFO with push and pop together: nothing lost, order kept.
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_commit(32'h4000 + 32'(4 * i), 32'h00100113, 5'd2, 32'(100 + i), 32'h0, 32'h0, 1'b0);
      tick();
      check("full_pp_count", cnt0, 3'd4);
    end
    cv = 1'b0;
    check("full_pp_drop0", drop0, 4'd2);
    check("full_pp_drop1", drop1, 4'd2);
    repeat (5) tick();
    check("drained_zero_fields0", {v0, kind0, pc0, instr0, rd0, data0, addr0, cnt0}, '0);
    check("drained_zero_fields1", {v1, kind1, pc1, instr1, rd1, data1, addr1, cnt1}, '0);
    rdy = 1'b0;

    // Statistics: 7 stall cycles with 3 disabled, 2 flush cycles; disabled commits are ignored.
    for (int i = 0; i < 7; i++) begin
      stall  = 1'b1;
      enable = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      flush  = (i == 0 || i == 5) ? 1'b1 : 1'b0;
      cv     = ~enable;
      tick();
    end
    stall = 1'b0; flush = 1'b0; enable = 1'b1; cv = 1'b0;
    check("stall_cnt", stc0, 4'd4);
    check("flush_cnt", flc0, 4'd2);
    check("disabled_no_capture", cnt0, 3'd0);

    // Randomized traffic in phases of differing consumer pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        enable = ($urandom_range(0, 7) != 0);
        stall  = ($urandom_range(0, 3) == 0);
        flush  = ($urandom_range(0, 7) == 0);
        rdy    = ($urandom_range(0, 3) < ph);
        if ($urandom_range(0, 1) == 1) rand_commit();
        else cv = 1'b0;
        tick();
      end
    end
    cv = 1'b0; stall = 1'b0; flush = 1'b0; enable = 1'b1;
    check("rand_drop0", drop0, mdrop0);
    check("rand_drop1", drop1, mdrop1);
    check("rand_stall", stc0, mstall);
    check("rand_flush", flc1, mflush);
    check("rand_count", cnt0, q0.size());
    rdy = 1'b1;
    repeat (6) tick();
    rdy = 1'b0;

    // Asynchronous reset in the middle of a burst with three records queued.
    for (int i = 0; i < 3; i++) begin
      set_commit(32'h5000 + 32'(4 * i), 32'h00100113, 5'd2, 32'(i), 32'h0, 32'h0, 1'b0);
      tick();
    end
    check("pre_reset_count", cnt0, 3'd3);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < SKIP + 1; i++) begin
      set_commit(32'h6000 + 32'(4 * i), 32'h00100113, 5'd2, 32'(i), 32'h0, 32'h0, 1'b0);
      tick();
      check("reskip_done", sd0, (i >= SKIP - 1) ? 1'b1 : 1'b0);
    end
    cv = 1'b0;
    check("reskip_count", cnt0, 3'd1);
    rdy = 1'b1;
    repeat (3) tick();
    check("final_count", cnt0, 3'd0);
    check("final_model_q0", q0.size(), 0);
    check("final_model_q1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable successor to the simulation-only commit logger in the core testbench. The block sits beside the riscv_multicycle core and captures each retired instruction as a classified trace record. Records go into a parametrised FIFO that a debug port or bench drains through a valid/ready handshake. It also counts pipeline stall and flush cycles, so trace and pipe statistics survive in silicon and do not depend on `$fwrite`.

## Interface
- XLEN, 32, data/address width of PC, register and memory fields
- DEPTH, 16, FIFO entries; power of two, ≥2
- SKIP, 3, number of commits discarded after reset (pipeline warm-up)
- OVERWRITE, 0, 0 = drop newest when full; 1 = evict oldest when full
- CNT_W, 32, width of statistic counters

- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- enable_i  in  1  capture and counting enable
- commit_valid_i  in  1  one instruction retires this cycle
- commit_pc_i  in  XLEN  PC of the retiring instruction
- commit_instr_i  in  32  instruction word
- commit_rd_i  in  5  destination register
- commit_rd_data_i  in  XLEN  value written to rd
- commit_mem_addr_i  in  XLEN  memory address
- commit_mem_data_i  in  XLEN  store data
- commit_mem_wrt_i  in  1  store flag
- stall_i  in  1  StallF or StallD asserted
- flush_i  in  1  FlushD or FlushE asserted
- rec_valid_o  out  1  head record available
- rec_ready_i  in  1  consumer accepts head
- rec_kind_o  out  2  0 NONE, 1 REG, 2 STORE, 3 LOAD
- rec_pc_o, rec_instr_o, rec_rd_o, rec_data_o, rec_addr_o  out  XLEN/32/5/XLEN/XLEN  head record fields
- count_o  out  $clog2(DEPTH+1)  occupancy
- dropped_o, stall_cnt_o, flush_cnt_o  out  CNT_W  statistics
- skip_done_o  out  1  warm-up commits consumed

## Operation
- Classification is evaluated in priority order:
  - STORE if commit_mem_wrt_i.
  - Else LOAD if instr[6:0]==7'b0000011.
  - Else NONE if rd==0.
  - Else REG.
- Record field rules:
  - data = rd_data for REG and LOAD, mem_data for STORE, 0 for NONE.
  - addr = mem_addr for STORE and LOAD, else 0.
  - rd is forced to 0 for STORE and NONE.
- Capture event: commit_valid_i & enable_i.
  - The first SKIP capture events after reset only increment the skip counter.
  - skip_done_o rises after the SKIP-th event. Skipped events are not counted as dropped.
- After skip_done_o, each capture event is a push.
- Pop: rec_valid_o & rec_ready_i.
- Full and no pop:
  - OVERWRITE=0: the new record is discarded and dropped_o increments.
  - OVERWRITE=1: the head is evicted, the new record is written, count stays DEPTH, and dropped_o increments.
- Full with a simultaneous pop and push: both happen, count is unchanged, nothing is dropped.
- Empty with a push: rec_ready_i has no effect that cycle.
- Counters:
  - stall_cnt_o increments on every cycle with stall_i & enable_i.
  - flush_cnt_o increments on every cycle with flush_i & enable_i.
  - All three counters saturate at all-ones and never wrap.
- enable_i=0 freezes capture and counting. Popping still works.
- rec_* fields drive 0 whenever count_o==0.

## Timing
- Reset (asynchronous, mid-operation included) clears all of the following on assertion, with no partial state retained: the FIFO pointers, count_o, rec_valid_o, every rec_* field, every counter, the skip counter, and skip_done_o.
- Push at edge k: rec_valid_o and the record are visible after edge k. Latency is 1 cycle and there is no combinational input→output path.
- Pop at edge k: the next entry, or empty, is presented after edge k. Back-to-back pops are sustained at 1 record/cycle.
- Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
- Counters update at the same edge as the event.

## Structure
- Package trace_pkg holds:
  - rec_kind_e (NONE/REG/STORE/LOAD)
  - trace_rec_t struct (kind, pc, instr, rd, data, addr)
  - OPC_LOAD constant
- Sub-module trace_fifo is a generic synchronous FIFO of trace_rec_t. It takes DEPTH and OVERWRITE parameters and provides full/empty/count. The top level does classification, skip and counters.

## Test plan
- Reset, then 5 commits with SKIP=3 → skip_done_o=1 after the 3rd; count_o=2; first record pc = the 4th commit's PC.
- Commit instr 0x00A00093 (addi x1, x0, 10), rd=1, data=0xA → kind REG, rd 1, data 0x0000000A, addr 0. Store with mem_wrt=1, addr 0x80000004, data 0xDEADBEEF → kind STORE, rd 0.
- DEPTH=4, OVERWRITE=0, 6 pushes with rec_ready_i=0 → count_o=4, dropped_o=2, head = 1st pushed record. Repeat with OVERWRITE=1 → head = 3rd pushed record, dropped_o=2.
- Full FIFO with a simultaneous push and pop for 8 cycles → count_o stays 4, dropped_o=0, records emerge in push order.
- Hold stall_i for 7 cycles and flush_i for 2, with enable_i low for 3 of the stall cycles → stall_cnt_o=4, flush_cnt_o=2.
- Assert rstn_i low mid-burst with count_o=3 → all outputs 0 immediately; after release the SKIP sequence restarts.
